// File: rtl/pergate_accum_fj_pkg.sv
// Shared sumcheck definitions: field parameters mirrored from the field macros,
// and the accumulator state encoding decoded by the round controller.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q 61'h1FFF_FFFF_FFFF_FFFF
`endif

package pergate_accum_fj_pkg;

    localparam int unsigned FW     = `F_NBITS;
    localparam logic [FW-1:0] FQ   = `F_Q;
    localparam int unsigned NTERMS = 3;

    typedef logic [FW-1:0] fe_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } accum_state_e;

endpackage

// File: rtl/pergate_accum_fj_field_adder.sv
// Combinational modular add; operands must already be reduced below FQ.
module field_adder
    import pergate_accum_fj_pkg::*;
(
    input  logic [FW-1:0] a_i,
    input  logic [FW-1:0] b_i,
    output logic [FW-1:0] sum_o
);

    logic [FW:0] wide;
    logic [FW:0] fq_w;
    logic [FW:0] diff;

    always_comb begin
        fq_w  = {1'b0, FQ};
        wide  = {1'b0, a_i} + {1'b0, b_i};
        diff  = wide - fq_w;
        sum_o = (wide >= fq_w) ? diff[FW-1:0] : wide[FW-1:0];
    end

endmodule

// File: rtl/pergate_accum_fj.sv
// Accumulates per-gate F_j(0..2) contribution triples modulo FQ and presents
// the round's sums once the programmed number of gates has been absorbed.
module pergate_accum_fj
    import pergate_accum_fj_pkg::*;
#(
    parameter int unsigned NGATES_BITS = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NGATES_BITS-1:0]        ngates,
    input  logic                          in_valid,
    input  logic [NTERMS-1:0][FW-1:0]     in_data,
    output logic                          in_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          done_pulse,
    output logic [NTERMS-1:0][FW-1:0]     fj
);

    accum_state_e                  state_q;
    logic [NGATES_BITS-1:0]        rem_q;
    logic [NTERMS-1:0][FW-1:0]     sum_q;
    logic [NTERMS-1:0][FW-1:0]     sum_d;
    logic                          in_ready_q;
    logic                          busy_q;
    logic                          done_q;
    logic                          done_pulse_q;

    for (genvar k = 0; k < NTERMS; k++) begin : g_add
        field_adder u_add (
            .a_i   (sum_q[k]),
            .b_i   (in_data[k]),
            .sum_o (sum_d[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rem_q        <= '0;
            sum_q        <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        sum_q <= '0;
                        rem_q <= ngates;
                        if (ngates == '0) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                            in_ready_q   <= 1'b0;
                            busy_q       <= 1'b0;
                        end else begin
                            state_q    <= ST_ACCUM;
                            done_q     <= 1'b0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        sum_q <= sum_d;
                        rem_q <= rem_q - 1'b1;
                        // Final contribution: leave ACCUM on the same edge that absorbs it.
                        if (rem_q == NGATES_BITS'(1)) begin
                            state_q      <= ST_DONE;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                            in_ready_q   <= 1'b0;
                            busy_q       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    rem_q      <= '0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign fj         = sum_q;

endmodule

// File: tb/tb_pergate_accum_fj.sv
// Randomized scoreboard bench for pergate_accum_fj against a modular-sum reference model.
module tb_pergate_accum_fj;
    import pergate_accum_fj_pkg::*;

    localparam int unsigned NB = 10;
    localparam logic [63:0] Q  = 64'(FQ);

    typedef logic [2:0][63:0] tri_t;
    typedef struct {
        tri_t        v;
        int unsigned cyc;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [NB-1:0]             ngates;
    logic                      in_valid;
    logic [NTERMS-1:0][FW-1:0] in_data;
    logic                      in_ready;
    logic                      busy;
    logic                      done;
    logic                      done_pulse;
    logic [NTERMS-1:0][FW-1:0] fj;

    pergate_accum_fj #(.NGATES_BITS(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .ngates     (ngates),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse),
        .fj         (fj)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t        q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned m_rem = 0;
    bit          m_done = 1'b0;
    tri_t        m_sum = '0;
    bit          mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic tri_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        tri_t t;
        t[0] = a; t[1] = b; t[2] = c;
        return t;
    endfunction

    function automatic logic [63:0] rnd_fe();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom % 4 == 0) return Q - 64'd1 - (r % 64'd4);
        return r % Q;
    endfunction

    function automatic tri_t rnd_tri();
        return mk(rnd_fe(), rnd_fe(), rnd_fe());
    endfunction

    task automatic drive_data(input tri_t d);
        for (int k = 0; k < 3; k++) in_data[k] = d[k][FW-1:0];
    endtask

    task automatic check_status();
        chk("in_ready", 64'(in_ready), 64'(m_rem != 0));
        chk("busy", 64'(busy), 64'(m_rem != 0));
        chk("done", 64'(done), 64'(m_done));
        for (int k = 0; k < 3; k++) chk($sformatf("fj%0d", k), 64'(fj[k]), m_sum[k]);
    endtask

    task automatic do_feed(input bit v, input tri_t d, input bit noise);
        @(negedge clk);
        check_status();
        rst      = 1'b0;
        in_valid = v;
        drive_data(d);
        start    = noise && (m_rem != 0);
        ngates   = NB'($urandom_range(0, 5));
        @(posedge clk); #1;
        if (v && m_rem != 0) begin
            for (int k = 0; k < 3; k++) m_sum[k] = (m_sum[k] + d[k]) % Q;
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                q.push_back('{v: m_sum, cyc: cyc});
            end
        end
    endtask

    task automatic do_start(input int unsigned n, input bit noise);
        @(negedge clk);
        check_status();
        rst      = 1'b0;
        start    = 1'b1;
        ngates   = NB'(n);
        in_valid = noise;
        drive_data(rnd_tri());
        @(posedge clk); #1;
        m_sum = '0;
        m_rem = n;
        m_done = (n == 0);
        if (n == 0) q.push_back('{v: '0, cyc: cyc});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        start    = 1'b1;
        ngates   = NB'(3);
        in_valid = 1'b1;
        drive_data(rnd_tri());
        @(posedge clk); #1;
        m_rem  = 0;
        m_done = 1'b0;
        m_sum  = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit   exp_p;
            exp_t e;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                total++;
                bad++;
                $display("FAIL done_pulse_missing: expected at cycle %0d, now %0d", e.cyc, cyc);
            end
            exp_p = (q.size() > 0) && (q[0].cyc == cyc);
            chk("done_pulse", 64'(done_pulse), 64'(exp_p));
            if (exp_p) begin
                e = q.pop_front();
                for (int k = 0; k < 3; k++) chk($sformatf("result_fj%0d", k), 64'(fj[k]), e.v[k]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; ngates = '0; in_valid = 1'b0; in_data = '0;
        do_reset();
        mon_en = 1'b1;
        do_reset();
        // reset then idle with stray input traffic
        repeat (4) do_feed(1'b1, rnd_tri(), 1'b0);

        // basic back-to-back round
        do_start(3, 1'b0);
        do_feed(1'b1, mk(1, 2, 3), 1'b0);
        do_feed(1'b1, mk(10, 20, 30), 1'b0);
        do_feed(1'b1, mk(100, 200, 300), 1'b0);
        repeat (2) do_feed(1'b0, rnd_tri(), 1'b0);

        // wrap-around at the modulus
        do_start(2, 1'b0);
        do_feed(1'b1, mk(Q - 1, Q - 1, 0), 1'b0);
        do_feed(1'b1, mk(2, 1, Q - 1), 1'b0);
        do_feed(1'b0, rnd_tri(), 1'b0);

        // gapped input, stray start in ACCUM, stray traffic afterwards
        do_start(2, 1'b1);
        do_feed(1'b1, rnd_tri(), 1'b0);
        repeat (3) do_feed(1'b0, rnd_tri(), 1'b1);
        do_feed(1'b1, rnd_tri(), 1'b0);
        repeat (3) do_feed(1'b1, rnd_tri(), 1'b0);

        // zero gates, then restart from DONE
        do_start(0, 1'b1);
        do_feed(1'b0, rnd_tri(), 1'b0);
        do_start(1, 1'b0);
        do_feed(1'b1, mk(7, 8, 9), 1'b0);
        do_feed(1'b0, rnd_tri(), 1'b0);

        // reset mid-round
        do_start(4, 1'b0);
        do_feed(1'b1, rnd_tri(), 1'b0);
        do_feed(1'b1, rnd_tri(), 1'b0);
        do_reset();
        do_feed(1'b0, rnd_tri(), 1'b0);
        do_start(1, 1'b0);
        do_feed(1'b1, mk(5, 5, 5), 1'b0);
        do_feed(1'b0, rnd_tri(), 1'b0);

        // randomized rounds
        repeat (40) begin
            do_start($urandom_range(0, 8), 1'($urandom % 2));
            while (m_rem != 0) begin
                if ($urandom % 25 == 0) do_reset();
                else do_feed(($urandom % 10) < 7, rnd_tri(), 1'($urandom % 2));
            end
            repeat ($urandom_range(0, 3)) do_feed(1'($urandom % 2), rnd_tri(), 1'b0);
        end

        repeat (3) do_feed(1'b0, rnd_tri(), 1'b0);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
